// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the exception controller: ExcCodes, CP0 register
// numbers, FSM state encoding and the Cause word packer.
package exc_ctrl_pkg;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_SYS = 5'd8;
   localparam logic [4:0] EXC_BP  = 5'd9;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;
   localparam logic [4:0] CP0_ERROREPC = 5'd30;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SAVE_EPC   = 3'd1,
      ST_SAVE_CAUSE = 3'd2,
      ST_SET_EXL    = 3'd3,
      ST_RET_CLR    = 3'd4,
      ST_REDIRECT   = 3'd5
   } state_t;

   // Cause layout: IP bits in [15:10], ExcCode in [6:2], everything else zero.
   function automatic logic [31:0] cause_word(input logic [5:0] ip, input logic [4:0] code);
      return {16'b0, ip, 3'b0, code, 2'b0};
   endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Request/response bundle between the pipeline/CP0 (master) and exc_ctrl (slave).
interface exc_ctrl_if #(
   parameter int IRQ_W = 6
);
   // Requests are levels held by the requester until the redirect pulse;
   // there is no ready: the controller simply ignores them while busy.
   logic [IRQ_W-1:0] irq;
   logic [3:0]       exc_req;
   logic [31:0]      exc_pc;
   logic             eret_req;
   logic [31:0]      status_in;
   logic [31:0]      epc_in;
   logic [31:0]      error_epc_in;

   logic             cp0_wr;
   logic [4:0]       cp0_num;
   logic [31:0]      cp0_data;
   logic             stall;
   logic             flush;
   logic             redirect;
   logic [31:0]      redirect_pc;
   logic             busy;

   modport master (
      output irq, exc_req, exc_pc, eret_req, status_in, epc_in, error_epc_in,
      input  cp0_wr, cp0_num, cp0_data, stall, flush, redirect, redirect_pc, busy
   );

   modport slave (
      input  irq, exc_req, exc_pc, eret_req, status_in, epc_in, error_epc_in,
      output cp0_wr, cp0_num, cp0_data, stall, flush, redirect, redirect_pc, busy
   );
endinterface

// File: rtl/exc_prio.sv
// Combinational priority encoder: Int > RI > Ov > Sys > Bp > eret.
module exc_prio
   import exc_ctrl_pkg::*;
(
   input  logic       i_int,
   input  logic [3:0] i_exc_req,
   input  logic       i_eret,
   output logic       o_valid,
   output logic [4:0] o_code,
   output logic       o_eret
);

   always_comb begin
      o_valid = 1'b1;
      o_code  = EXC_INT;
      o_eret  = 1'b0;
      if (i_int)             o_code = EXC_INT;
      else if (i_exc_req[3]) o_code = EXC_RI;
      else if (i_exc_req[2]) o_code = EXC_OV;
      else if (i_exc_req[1]) o_code = EXC_SYS;
      else if (i_exc_req[0]) o_code = EXC_BP;
      else begin
         o_valid = 1'b0;
         o_eret  = i_eret;
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception entry / ERET sequencer: saves EPC, Cause, Status through the single
// CP0 write port one register per cycle, then redirects fetch.
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_3000,
   parameter int          IRQ_W      = 6
) (
   input  logic         clk,
   input  logic         rst,
   exc_ctrl_if.slave    bus,
   output state_t       o_state
);

   state_t      r_state;
   state_t      w_next;
   logic [31:0] r_pc;
   logic [31:0] r_target;
   logic [4:0]  r_code;
   logic [5:0]  r_ip;

   logic [5:0]  w_irq6;
   logic [5:0]  w_ip;
   logic        w_int;
   logic        w_valid;
   logic [4:0]  w_code;
   logic        w_eret;

   logic        w_cp0_wr;
   logic [4:0]  w_cp0_num;
   logic [31:0] w_cp0_data;
   logic        w_stall;
   logic        w_flush;
   logic        w_redirect;
   logic [31:0] w_redirect_pc;

   always_comb begin
      w_irq6 = '0;
      for (int i = 0; i < IRQ_W && i < 6; i++) w_irq6[i] = bus.irq[i];
   end

   // Interrupts are taken only with IE=1 and neither EXL nor ERL set.
   assign w_ip  = w_irq6 & bus.status_in[15:10];
   assign w_int = (|w_ip) & bus.status_in[0] & ~bus.status_in[1] & ~bus.status_in[2];

   exc_prio u_prio (
      .i_int     (w_int),
      .i_exc_req (bus.exc_req),
      .i_eret    (bus.eret_req),
      .o_valid   (w_valid),
      .o_code    (w_code),
      .o_eret    (w_eret)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_pc     <= '0;
         r_target <= '0;
         r_code   <= '0;
         r_ip     <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == ST_IDLE) begin
            if (w_valid) begin
               r_pc     <= bus.exc_pc;
               r_target <= EXC_VECTOR;
               r_code   <= w_code;
               r_ip     <= w_ip;
            end else if (w_eret) begin
               r_target <= bus.status_in[2] ? bus.error_epc_in : bus.epc_in;
            end
         end
      end
   end

   always_comb begin
      w_next        = r_state;
      w_cp0_wr      = 1'b0;
      w_cp0_num     = '0;
      w_cp0_data    = '0;
      w_stall       = 1'b0;
      w_flush       = 1'b0;
      w_redirect    = 1'b0;
      w_redirect_pc = '0;
      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_flush = 1'b1;
               w_next  = ST_SAVE_EPC;
            end else if (w_eret) begin
               w_flush = 1'b1;
               w_next  = ST_RET_CLR;
            end
         end
         ST_SAVE_EPC: begin
            w_cp0_wr   = 1'b1;
            w_cp0_num  = CP0_EPC;
            w_cp0_data = r_pc;
            w_stall    = 1'b1;
            w_next     = ST_SAVE_CAUSE;
         end
         ST_SAVE_CAUSE: begin
            w_cp0_wr   = 1'b1;
            w_cp0_num  = CP0_CAUSE;
            w_cp0_data = cause_word(r_ip, r_code);
            w_stall    = 1'b1;
            w_next     = ST_SET_EXL;
         end
         ST_SET_EXL: begin
            w_cp0_wr   = 1'b1;
            w_cp0_num  = CP0_STATUS;
            w_cp0_data = bus.status_in | 32'h0000_0002;
            w_stall    = 1'b1;
            w_next     = ST_REDIRECT;
         end
         ST_RET_CLR: begin
            // ERL takes precedence over EXL when both are set.
            w_cp0_wr   = 1'b1;
            w_cp0_num  = CP0_STATUS;
            w_cp0_data = bus.status_in[2] ? (bus.status_in & ~32'h0000_0004)
                                          : (bus.status_in & ~32'h0000_0002);
            w_stall    = 1'b1;
            w_next     = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            w_redirect    = 1'b1;
            w_redirect_pc = r_target;
            w_next        = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Reset silences every output in the same cycle so an aborted sequence
   // never leaks a CP0 write or redirect.
   assign bus.cp0_wr      = w_cp0_wr & ~rst;
   assign bus.cp0_num     = rst ? 5'd0 : w_cp0_num;
   assign bus.cp0_data    = rst ? 32'd0 : w_cp0_data;
   assign bus.stall       = w_stall & ~rst;
   assign bus.flush       = w_flush & ~rst;
   assign bus.redirect    = w_redirect & ~rst;
   assign bus.redirect_pc = rst ? 32'd0 : w_redirect_pc;
   assign bus.busy        = (r_state != ST_IDLE) & ~rst;
   assign o_state         = r_state;

endmodule
